// File: rtl/bomb_scheduler_if.sv
// Bomb scheduler bus: player bomb requests and positions in, grants and
// per-slot bomb rectangles/state out.
// Request/grant handshake: reqN is a level held while the key is down; only
// its rising edge is a request. grantN is a one-frame pulse meaning "bomb
// placed". A request that cannot be served that frame is dropped, not queued.
interface bomb_scheduler_if;
    logic       req1, req2;
    logic [9:0] p1X, p1Y, p2X, p2Y;
    logic       grant1, grant2;
    logic [9:0] bomb0X, bomb0Y, bomb0XS, bomb0YS;
    logic [9:0] bomb1X, bomb1Y, bomb1XS, bomb1YS;
    logic [1:0] bomb0_state, bomb1_state;
    logic       owner0, owner1;

    // Player/arena side
    modport master (
        output req1, req2, p1X, p1Y, p2X, p2Y,
        input  grant1, grant2,
        input  bomb0X, bomb0Y, bomb0XS, bomb0YS,
        input  bomb1X, bomb1Y, bomb1XS, bomb1YS,
        input  bomb0_state, bomb1_state, owner0, owner1
    );

    // Scheduler side
    modport slave (
        input  req1, req2, p1X, p1Y, p2X, p2Y,
        output grant1, grant2,
        output bomb0X, bomb0Y, bomb0XS, bomb0YS,
        output bomb1X, bomb1Y, bomb1XS, bomb1YS,
        output bomb0_state, bomb1_state, owner0, owner1
    );
endinterface

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: arbitrates both players' bomb drops onto two slots, snaps
// bombs to the tile grid and times each slot through FUSE and EXPLODE.
// Optional macro CHAIN_REACTION_EN: a fusing bomb inside another slot's blast
// rectangle detonates early.
module bomb_scheduler #(
    parameter int TILE_LOG2      = 5,
    parameter int FUSE_FRAMES    = 120,
    parameter int EXPLODE_FRAMES = 30,
    parameter int HALF_X         = 10,
    parameter int HALF_Y         = 13
) (
    input  logic             frame_clk,
    input  logic             Reset,
    bomb_scheduler_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FUSE    = 2'd1;
    localparam logic [1:0] S_EXPLODE = 2'd2;

    localparam int CNT_MAX = (FUSE_FRAMES > EXPLODE_FRAMES) ? FUSE_FRAMES : EXPLODE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FUSE_LOAD    = CNT_W'(FUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0] EXPLODE_LOAD = CNT_W'(EXPLODE_FRAMES - 1);

    localparam logic [9:0] TILE      = 10'(1 << TILE_LOG2);
    localparam logic [9:0] TILE_MASK = ~(TILE - 10'd1);
    localparam logic [9:0] BLAST     = 10'(3 * (1 << TILE_LOG2));

    logic             req1_q, req2_q, rr_q, rr_d;
    logic             grant1_q, grant1_d, grant2_q, grant2_d;
    logic [1:0]       state_q [2], state_d [2];
    logic [CNT_W-1:0] cnt_q   [2], cnt_d   [2];
    logic [9:0]       tx_q    [2], tx_d    [2];
    logic [9:0]       ty_q    [2], ty_d    [2];
    logic             own_q   [2], own_d   [2];
    logic [9:0]       x_q [2], x_d [2], y_q [2], y_d [2];
    logic [9:0]       xs_q [2], xs_d [2], ys_q [2], ys_d [2];

    logic [9:0] t1x, t1y, t2x, t2y, fx, fy, sx, sy;
    logic       busy0, busy1, owns1, owns2, hit1, hit2, elig1, elig2;
    logic       first_elig, second_elig, first_gets, second_gets;
    logic       first_slot, second_slot, first_own;
    logic       alloc [2], alloc_own [2];
    logic [9:0] alloc_x [2], alloc_y [2];
    logic       chain_hit [2];

    // Tile snapping, slot ownership and tile-collision checks for both players
    always_comb begin
        t1x   = (bus.p1X + 10'(HALF_X)) & TILE_MASK;
        t1y   = (bus.p1Y + 10'(HALF_Y)) & TILE_MASK;
        t2x   = (bus.p2X + 10'(HALF_X)) & TILE_MASK;
        t2y   = (bus.p2Y + 10'(HALF_Y)) & TILE_MASK;
        busy0 = (state_q[0] != S_IDLE);
        busy1 = (state_q[1] != S_IDLE);
        owns1 = (busy0 && !own_q[0]) || (busy1 && !own_q[1]);
        owns2 = (busy0 && own_q[0]) || (busy1 && own_q[1]);
        hit1  = (busy0 && tx_q[0] == t1x && ty_q[0] == t1y) ||
                (busy1 && tx_q[1] == t1x && ty_q[1] == t1y);
        hit2  = (busy0 && tx_q[0] == t2x && ty_q[0] == t2y) ||
                (busy1 && tx_q[1] == t2x && ty_q[1] == t2y);
        elig1 = bus.req1 && !req1_q && !owns1 && !hit1;
        elig2 = bus.req2 && !req2_q && !owns2 && !hit2;
    end

    // Round-robin allocation: rr winner picks first, each takes lowest idle slot
    always_comb begin
        first_own   = rr_q;
        first_elig  = rr_q ? elig2 : elig1;
        second_elig = rr_q ? elig1 : elig2;
        fx = rr_q ? t2x : t1x;
        fy = rr_q ? t2y : t1y;
        sx = rr_q ? t1x : t2x;
        sy = rr_q ? t1y : t2y;
        first_gets  = first_elig && (!busy0 || !busy1);
        first_slot  = busy0;
        second_gets = second_elig && !(first_gets && fx == sx && fy == sy) &&
                      (first_gets ? (!busy0 && !busy1) : (!busy0 || !busy1));
        second_slot = first_gets ? 1'b1 : busy0;
        for (int i = 0; i < 2; i++) begin
            alloc[i]     = 1'b0;
            alloc_own[i] = 1'b0;
            alloc_x[i]   = 10'd0;
            alloc_y[i]   = 10'd0;
            if (first_gets && first_slot == 1'(i)) begin
                alloc[i]     = 1'b1;
                alloc_own[i] = first_own;
                alloc_x[i]   = fx;
                alloc_y[i]   = fy;
            end else if (second_gets && second_slot == 1'(i)) begin
                alloc[i]     = 1'b1;
                alloc_own[i] = !first_own;
                alloc_x[i]   = sx;
                alloc_y[i]   = sy;
            end
        end
        grant1_d = rr_q ? second_gets : first_gets;
        grant2_d = rr_q ? first_gets : second_gets;
        rr_d     = rr_q ^ (first_gets ^ second_gets);
    end

`ifdef CHAIN_REACTION_EN
    // Early detonation: own tile strictly inside the other slot's blast rectangle
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            chain_hit[i] = (state_q[1-i] == S_EXPLODE) &&
                ({1'b0, tx_q[i]} > {1'b0, x_q[1-i]}) &&
                ({1'b0, tx_q[i]} < ({1'b0, x_q[1-i]} + {1'b0, xs_q[1-i]})) &&
                ({1'b0, ty_q[i]} > {1'b0, y_q[1-i]}) &&
                ({1'b0, ty_q[i]} < ({1'b0, y_q[1-i]} + {1'b0, ys_q[1-i]}));
        end
    end
`else
    // Slots are independent: no early detonation
    always_comb begin
        for (int i = 0; i < 2; i++) chain_hit[i] = 1'b0;
    end
`endif

    // Per-slot FSM next state and the rectangle it will present
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            tx_d[i]    = tx_q[i];
            ty_d[i]    = ty_q[i];
            own_d[i]   = own_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (alloc[i]) begin
                        state_d[i] = S_FUSE;
                        cnt_d[i]   = FUSE_LOAD;
                        tx_d[i]    = alloc_x[i];
                        ty_d[i]    = alloc_y[i];
                        own_d[i]   = alloc_own[i];
                    end
                end
                S_FUSE: begin
                    if (cnt_q[i] == '0 || chain_hit[i]) begin
                        state_d[i] = S_EXPLODE;
                        cnt_d[i]   = EXPLODE_LOAD;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                S_EXPLODE: begin
                    if (cnt_q[i] == '0) state_d[i] = S_IDLE;
                    else                cnt_d[i]   = cnt_q[i] - 1'b1;
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            x_d[i]  = 10'd0;
            y_d[i]  = 10'd0;
            xs_d[i] = 10'd0;
            ys_d[i] = 10'd0;
            if (state_d[i] == S_FUSE) begin
                x_d[i] = tx_d[i];
                y_d[i] = ty_d[i];
            end else if (state_d[i] == S_EXPLODE) begin
                x_d[i]  = tx_d[i] - TILE;
                y_d[i]  = ty_d[i] - TILE;
                xs_d[i] = BLAST;
                ys_d[i] = BLAST;
            end
        end
    end

    // State, history and output registers with synchronous reset
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            req1_q   <= 1'b0;
            req2_q   <= 1'b0;
            rr_q     <= 1'b0;
            grant1_q <= 1'b0;
            grant2_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                tx_q[i]    <= 10'd0;
                ty_q[i]    <= 10'd0;
                own_q[i]   <= 1'b0;
                x_q[i]     <= 10'd0;
                y_q[i]     <= 10'd0;
                xs_q[i]    <= 10'd0;
                ys_q[i]    <= 10'd0;
            end
        end else begin
            req1_q   <= bus.req1;
            req2_q   <= bus.req2;
            rr_q     <= rr_d;
            grant1_q <= grant1_d;
            grant2_q <= grant2_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                tx_q[i]    <= tx_d[i];
                ty_q[i]    <= ty_d[i];
                own_q[i]   <= own_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                xs_q[i]    <= xs_d[i];
                ys_q[i]    <= ys_d[i];
            end
        end
    end

    assign bus.grant1      = grant1_q;
    assign bus.grant2      = grant2_q;
    assign bus.bomb0X      = x_q[0];
    assign bus.bomb0Y      = y_q[0];
    assign bus.bomb0XS     = xs_q[0];
    assign bus.bomb0YS     = ys_q[0];
    assign bus.bomb1X      = x_q[1];
    assign bus.bomb1Y      = y_q[1];
    assign bus.bomb1XS     = xs_q[1];
    assign bus.bomb1YS     = ys_q[1];
    assign bus.bomb0_state = state_q[0];
    assign bus.bomb1_state = state_q[1];
    assign bus.owner0      = own_q[0];
    assign bus.owner1      = own_q[1];
endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
- Shared bomb-slot controller for the two-player arena.
- Takes the `bomb_drop` requests from both player controllers and arbitrates them onto two bomb slots.
- Snaps each placed bomb to the 32-px tile grid and times each slot through fuse and explosion.
- Drives the bomb rectangle (X, Y, XS, YS) that the player controllers use for blast collision, plus per-slot state for the sprite renderer.

Parameters:
- TILE_LOG2, 5, log2 of tile edge in pixels (tile = 32).
- FUSE_FRAMES, 120, frames a slot stays in FUSE.
- EXPLODE_FRAMES, 30, frames a slot stays in EXPLODE.
- HALF_X, 10, player sprite half-width, used for centre snapping.
- HALF_Y, 13, player sprite half-height, used for centre snapping.

Ports:
- frame_clk  in  1  frame-rate clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req1  in  1  player 1 `bomb_drop`, a level held while the key is down.
- req2  in  1  player 2 `bomb_drop`, a level held while the key is down.
- p1X, p1Y  in  10 each  player 1 top-left position.
- p2X, p2Y  in  10 each  player 2 top-left position.
- grant1  out  1  one-frame pulse: player 1 bomb placed.
- grant2  out  1  one-frame pulse: player 2 bomb placed.
- bomb0X, bomb0Y, bomb0XS, bomb0YS  out  10 each  slot 0 rectangle.
- bomb1X, bomb1Y, bomb1XS, bomb1YS  out  10 each  slot 1 rectangle.
- bomb0_state  out  2  slot 0 state: 0 IDLE, 1 FUSE, 2 EXPLODE.
- bomb1_state  out  2  slot 1 state: 0 IDLE, 1 FUSE, 2 EXPLODE.
- owner0  out  1  owner of slot 0: 0 = P1, 1 = P2.
- owner1  out  1  owner of slot 1: 0 = P1, 1 = P2.

Behaviour:
- Reset (synchronous; takes effect at the next edge, including mid-fuse or mid-explosion):
  - all slots IDLE, counters 0, all rectangle outputs 0, grants 0, owners 0.
  - req history registers 0; round-robin pointer rr = P1.
- All outputs are registered.
- Request detection: a request is valid at an edge when reqN = 1 and reqN_q = 0 (rising edge only). Holding the key never places a second bomb.
- A player is eligible when all three hold:
  - the request is valid;
  - the player owns no slot in FUSE or EXPLODE;
  - the player's snapped tile does not equal the tile of any non-IDLE slot.
- Snapping: tileX = (pX + HALF_X) with the low TILE_LOG2 bits cleared; tileY likewise with HALF_Y. Unsigned 10-bit arithmetic; players are bounded ≥ 32, so tileX/tileY ≥ 32.
- Allocation, same edge:
  - Eligible players are served in rr order; each takes the lowest-indexed IDLE slot.
  - If two players are eligible with one free slot, or both target the same tile, only the rr winner is granted.
  - rr then points to the other player, and toggles after every grant.
  - If no slot is free, the request is dropped, not queued.
- Per-slot FSM:
  - IDLE → FUSE on allocation: latch tile, latch owner, counter = FUSE_FRAMES-1, grant pulse for 1 frame.
  - FUSE: counter decrements each edge; at 0 → EXPLODE with counter = EXPLODE_FRAMES-1.
  - EXPLODE: counter decrements each edge; at 0 → IDLE.
  - A slot entering IDLE at edge k is allocatable at edge k+1, not at k.
- Rectangle outputs:
  - IDLE: X = Y = XS = YS = 0.
  - FUSE: X = tileX, Y = tileY, XS = YS = 0. Zero size, so it is never lethal to the players' strict ">" checks.
  - EXPLODE: X = tileX - tile, Y = tileY - tile, XS = YS = 3·tile (96), covering the 3×3-tile blast.
- Timing: a bomb is placed at edge k, is in EXPLODE from edge k+FUSE_FRAMES, and returns to IDLE at edge k+FUSE_FRAMES+EXPLODE_FRAMES.

Optional Feature:
- Macro: CHAIN_REACTION_EN.
- Defined: at each edge, a FUSE slot whose tile lies inside another slot's EXPLODE rectangle (tile > X, tile < X+XS, for both axes) enters EXPLODE at the next edge with counter = EXPLODE_FRAMES-1. Its owner's grant logic is unaffected.
- Undefined: slots are fully independent; no cross-slot comparison logic is built.

Test Plan:
- Reset, then hold req1 = 1 for 10 frames with p1 = (100, 200) → grant1 pulses once at the first edge; slot 0 in FUSE at (96, 192), XS = YS = 0, owner0 = 0; no second grant.
- From the placement above, run 150 frames → EXPLODE at edge +120 with rect (64, 160, 96, 96); IDLE with all-zero rect at edge +150.
- Rising edges on req1 and req2 in the same frame, both at tile (96, 192) → only grant1 (rr = P1); repeat after IDLE at distinct tiles → both granted, P2 gets slot 0 since rr = P2.
- Both slots busy, player 1 presses again → no grant; press at the edge where a slot goes IDLE → no grant; press one frame later → grant.
- Reset asserted mid-EXPLODE → next edge: all outputs 0, rr = P1; a new req1 edge is granted slot 0.
- CHAIN_REACTION_EN: P1 bomb at (96, 192), P2 bomb at (128, 192) placed 20 frames later → slot 1 enters EXPLODE one edge after slot 0 does.
